// File: rtl/matmul_gen_top.sv
// Parametrised M x K by K x P matrix multiply with optional accumulate into Z.
// X, Y and Z live in private synchronous RAMs; the host loads X/Y, pulses start, reads Z.
module matmul_gen_top #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned M          = 8,
    parameter int unsigned K          = 8,
    parameter int unsigned P          = 8,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_x_din,
    input  logic [ADDR_WIDTH-1:0] i_x_wr_addr,
    input  logic                  i_x_wr_en,
    input  logic [DATA_WIDTH-1:0] i_y_din,
    input  logic [ADDR_WIDTH-1:0] i_y_wr_addr,
    input  logic                  i_y_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_z_rd_addr,
    output logic [DATA_WIDTH-1:0] o_z_dout,
    input  logic                  i_start,
    input  logic                  i_acc,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam int unsigned IW    = $clog2(M + 1);
    localparam int unsigned JW    = $clog2(P + 1);
    localparam int unsigned KW    = $clog2(K + 1);

    localparam logic [IW-1:0] MLast = IW'(M - 1);
    localparam logic [JW-1:0] PLast = JW'(P - 1);
    localparam logic [KW-1:0] KCnt  = KW'(K);

    typedef enum logic [1:0] {StIdle, StRun, StWr, StFin} state_e;

    state_e                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_acc_mode;
    logic [IW-1:0]         r_i;
    logic [JW-1:0]         r_j;
    logic [KW-1:0]         r_k;
    logic                  r_rd_vld;
    logic                  r_first;
    logic [DATA_WIDTH-1:0] r_acc;

    logic [DATA_WIDTH-1:0] r_x_mem [Depth];
    logic [DATA_WIDTH-1:0] r_y_mem [Depth];
    logic [DATA_WIDTH-1:0] r_z_mem [Depth];
    logic [DATA_WIDTH-1:0] r_x_q;
    logic [DATA_WIDTH-1:0] r_y_q;
    logic [DATA_WIDTH-1:0] r_z_q;
    logic                  r_z_host;

    logic                  w_x_we;
    logic                  w_y_we;
    logic                  w_z_we;
    logic [ADDR_WIDTH-1:0] w_x_raddr;
    logic [ADDR_WIDTH-1:0] w_y_raddr;
    logic [ADDR_WIDTH-1:0] w_z_eaddr;
    logic [ADDR_WIDTH-1:0] w_z_raddr;
    logic                  w_host_rd;
    logic [DATA_WIDTH-1:0] w_prod;
    logic [DATA_WIDTH-1:0] w_seed;

    // Operands are frozen for the whole run
    assign w_x_we = i_x_wr_en && !r_busy;
    assign w_y_we = i_y_wr_en && !r_busy;
    assign w_z_we = (r_state == StWr);

    assign w_x_raddr = ADDR_WIDTH'(32'(r_i) * 32'(K) + 32'(r_k));
    assign w_y_raddr = ADDR_WIDTH'(32'(r_k) * 32'(P) + 32'(r_j));
    assign w_z_eaddr = ADDR_WIDTH'(32'(r_i) * 32'(P) + 32'(r_j));

    // The sequencer owns the Z read port while iterating; otherwise the host does
    assign w_z_raddr = (r_state == StRun) ? w_z_eaddr : i_z_rd_addr;
    assign w_host_rd = ((r_state == StIdle) && !i_start) || (r_state == StFin);

    assign w_prod = r_x_q * r_y_q;
    assign w_seed = r_acc_mode ? r_z_q : '0;

    always_ff @(posedge i_clk) begin
        if (w_x_we) r_x_mem[i_x_wr_addr] <= i_x_din;
        if (w_y_we) r_y_mem[i_y_wr_addr] <= i_y_din;
        if (w_z_we) r_z_mem[w_z_eaddr]   <= r_acc;
        r_x_q <= r_x_mem[w_x_raddr];
        r_y_q <= r_y_mem[w_y_raddr];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_z_q    <= '0;
            r_z_host <= 1'b0;
        end else begin
            r_z_q    <= r_z_mem[w_z_raddr];
            r_z_host <= w_host_rd;
        end
    end

    assign o_z_dout = r_z_host ? r_z_q : '0;
    assign o_busy   = r_busy;
    assign o_done   = r_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_acc_mode <= 1'b0;
            r_i        <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_rd_vld   <= 1'b0;
            r_first    <= 1'b0;
            r_acc      <= '0;
        end else begin
            r_done   <= 1'b0;
            r_rd_vld <= 1'b0;
            r_first  <= 1'b0;
            // Read data lands one cycle after the address; the k=0 product seeds the sum
            if (r_rd_vld) begin
                r_acc <= (r_first ? w_seed : r_acc) + w_prod;
            end
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_acc_mode <= i_acc;
                        r_i        <= '0;
                        r_j        <= '0;
                        r_k        <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= StRun;
                    end
                end
                StRun: begin
                    if (r_k < KCnt) begin
                        r_rd_vld <= 1'b1;
                        r_first  <= (r_k == '0);
                        r_k      <= r_k + 1'b1;
                    end else begin
                        r_k     <= '0;
                        r_state <= StWr;
                    end
                end
                StWr: begin
                    if (r_j == PLast) begin
                        r_j <= '0;
                        if (r_i == MLast) begin
                            r_i     <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= StFin;
                        end else begin
                            r_i     <= r_i + 1'b1;
                            r_state <= StRun;
                        end
                    end else begin
                        r_j     <= r_j + 1'b1;
                        r_state <= StRun;
                    end
                end
                StFin: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_gen_top.sv
// Bench for matmul_gen_top: three instances (2x3x2, 8x8x8, 1x1x1) driven by directed
// and random runs, results compared against literal values and an arithmetic model.
module tb_matmul_gen_top;

    logic clk;
    logic rst_n;

    logic [31:0] x_din [3];
    logic [5:0]  x_wa  [3];
    logic        x_we  [3];
    logic [31:0] y_din [3];
    logic [5:0]  y_wa  [3];
    logic        y_we  [3];
    logic [5:0]  z_ra  [3];
    logic        start [3];
    logic        acc   [3];

    logic [31:0] z_dout0, z_dout1, z_dout2;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;

    int n_cmp;
    int n_fail;

    int dm [3] = '{2, 8, 1};
    int dp [3] = '{2, 8, 1};

    logic [31:0] exp_base [4] = '{32'd58, 32'd64, 32'd139, 32'd154};
    logic [31:0] exp_acc  [4] = '{32'd116, 32'd128, 32'd278, 32'd308};

    // Reference operands and result for the 8x8x8 instance
    logic [31:0] rx [64];
    logic [31:0] ry [64];
    logic [31:0] rz [64];

    matmul_gen_top #(.DATA_WIDTH(32), .M(2), .K(3), .P(2), .ADDR_WIDTH(6)) u_dut_small (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_x_din(x_din[0]), .i_x_wr_addr(x_wa[0]), .i_x_wr_en(x_we[0]),
        .i_y_din(y_din[0]), .i_y_wr_addr(y_wa[0]), .i_y_wr_en(y_we[0]),
        .i_z_rd_addr(z_ra[0]), .o_z_dout(z_dout0),
        .i_start(start[0]), .i_acc(acc[0]), .o_busy(busy0), .o_done(done0)
    );

    matmul_gen_top u_dut_def (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_x_din(x_din[1]), .i_x_wr_addr(x_wa[1]), .i_x_wr_en(x_we[1]),
        .i_y_din(y_din[1]), .i_y_wr_addr(y_wa[1]), .i_y_wr_en(y_we[1]),
        .i_z_rd_addr(z_ra[1]), .o_z_dout(z_dout1),
        .i_start(start[1]), .i_acc(acc[1]), .o_busy(busy1), .o_done(done1)
    );

    matmul_gen_top #(.DATA_WIDTH(32), .M(1), .K(1), .P(1), .ADDR_WIDTH(6)) u_dut_wrap (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_x_din(x_din[2]), .i_x_wr_addr(x_wa[2]), .i_x_wr_en(x_we[2]),
        .i_y_din(y_din[2]), .i_y_wr_addr(y_wa[2]), .i_y_wr_en(y_we[2]),
        .i_z_rd_addr(z_ra[2]), .o_z_dout(z_dout2),
        .i_start(start[2]), .i_acc(acc[2]), .o_busy(busy2), .o_done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic get_busy(input int sel);
        case (sel)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic get_done(input int sel);
        case (sel)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    function automatic logic [31:0] get_z(input int sel);
        case (sel)
            0:       return z_dout0;
            1:       return z_dout1;
            default: return z_dout2;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr_x(input int sel, input int a, input logic [31:0] v);
        x_we[sel] = 1'b1;
        x_wa[sel] = 6'(a);
        x_din[sel] = v;
        @(negedge clk);
        x_we[sel] = 1'b0;
        if (sel == 1) rx[a] = v;
    endtask

    task automatic wr_y(input int sel, input int a, input logic [31:0] v);
        y_we[sel] = 1'b1;
        y_wa[sel] = 6'(a);
        y_din[sel] = v;
        @(negedge clk);
        y_we[sel] = 1'b0;
        if (sel == 1) ry[a] = v;
    endtask

    task automatic rd_z(input int sel, input int a, output logic [31:0] v);
        z_ra[sel] = 6'(a);
        @(negedge clk);
        v = get_z(sel);
    endtask

    // Z = X*Y (or Z + X*Y) straight from the definition, 32-bit wrapping
    task automatic model_run(input bit accm);
        logic [31:0] s;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                s = accm ? rz[i*8+j] : 32'd0;
                for (int k = 0; k < 8; k++) s = s + rx[i*8+k] * ry[k*8+j];
                rz[i*8+j] = s;
            end
        end
    endtask

    // One run: counts busy cycles and done pulses (including a quiet window after),
    // and reads the last Z element starting in the cycle done is seen.
    task automatic run(input int sel, input logic accv, input bit disturb,
                       output int bcnt, output int dcnt, output logic [31:0] last_z);
        bit seen;
        bcnt = 0;
        dcnt = 0;
        seen = 1'b0;
        last_z = 32'hdead_beef;
        start[sel] = 1'b1;
        acc[sel] = accv;
        @(negedge clk);
        start[sel] = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            if (c == 2) check("zdout_zero_while_busy", get_z(sel), 32'd0);
            if (disturb && c == 3) begin
                x_we[sel] = 1'b1; x_wa[sel] = 6'd0; x_din[sel] = 32'd99; start[sel] = 1'b1;
            end
            if (disturb && c == 4) begin
                x_we[sel] = 1'b0; start[sel] = 1'b0;
            end
            if (get_done(sel)) begin
                dcnt++;
                seen = 1'b1;
                check("busy_low_at_done", 32'(get_busy(sel)), 32'd0);
            end else begin
                if (get_busy(sel)) bcnt++;
                @(negedge clk);
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            z_ra[sel] = 6'(dm[sel] * dp[sel] - 1);
            @(negedge clk);
            last_z = get_z(sel);
            if (get_done(sel)) dcnt++;
            if (get_busy(sel)) bcnt++;
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                if (get_done(sel)) dcnt++;
                if (get_busy(sel)) bcnt++;
            end
        end
    endtask

    task automatic check_small(input string tag, input bit use_acc);
        logic [31:0] v;
        for (int a = 0; a < 4; a++) begin
            rd_z(0, a, v);
            check(tag, v, use_acc ? exp_acc[a] : exp_base[a]);
        end
    endtask

    task automatic check_def_model(input string tag);
        logic [31:0] v;
        for (int a = 0; a < 64; a++) begin
            rd_z(1, a, v);
            check(tag, v, rz[a]);
        end
    endtask

    initial begin
        int b;
        int d;
        logic [31:0] l;
        logic [31:0] v;
        n_cmp = 0;
        n_fail = 0;
        for (int s = 0; s < 3; s++) begin
            x_din[s] = '0; x_wa[s] = '0; x_we[s] = 1'b0;
            y_din[s] = '0; y_wa[s] = '0; y_we[s] = 1'b0;
            z_ra[s] = '0; start[s] = 1'b0; acc[s] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check("reset_busy", 32'(get_busy(s)), 32'd0);
            check("reset_done", 32'(get_done(s)), 32'd0);
            check("reset_zdout", get_z(s), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Non-square 2x3x2
        for (int a = 0; a < 6; a++) wr_x(0, a, 32'(a + 1));
        for (int a = 0; a < 6; a++) wr_y(0, a, 32'(a + 7));
        run(0, 1'b0, 1'b0, b, d, l);
        check("ns_busy_cycles", 32'(b), 32'd20);
        check("ns_done_pulses", 32'(d), 32'd1);
        check("ns_read_at_done", l, 32'd154);
        check_small("ns_z", 1'b0);

        run(0, 1'b1, 1'b0, b, d, l);
        check("acc_busy_cycles", 32'(b), 32'd20);
        check("acc_done_pulses", 32'(d), 32'd1);
        check("acc_read_at_done", l, 32'd308);
        check_small("acc_z", 1'b1);

        // Host write and start during busy must be dropped
        run(0, 1'b0, 1'b1, b, d, l);
        check("prot_busy_cycles", 32'(b), 32'd20);
        check("prot_done_pulses", 32'(d), 32'd1);
        check("prot_read_at_done", l, 32'd154);
        run(0, 1'b0, 1'b0, b, d, l);
        check("prot_rerun_done", 32'(d), 32'd1);
        check_small("prot_x_unchanged_z", 1'b0);

        // Reset in the middle of a run
        start[0] = 1'b1; acc[0] = 1'b0;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy0), 32'd0);
        check("midrst_done", 32'(done0), 32'd0);
        check("midrst_zdout", z_dout0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(0, 1'b0, 1'b0, b, d, l);
        check("midrst_rerun_busy", 32'(b), 32'd20);
        check_small("midrst_rerun_z", 1'b0);

        // 8x8x8 identity
        for (int a = 0; a < 64; a++) wr_x(1, a, 32'(a));
        for (int a = 0; a < 64; a++) wr_y(1, a, (a / 8 == a % 8) ? 32'd1 : 32'd0);
        run(1, 1'b0, 1'b0, b, d, l);
        model_run(1'b0);
        check("id_busy_cycles", 32'(b), 32'd640);
        check("id_done_pulses", 32'(d), 32'd1);
        for (int a = 0; a < 64; a++) begin
            rd_z(1, a, v);
            check("id_z", v, 32'(a));
        end

        // 8x8x8 random overwrite, then random accumulate
        for (int a = 0; a < 64; a++) wr_x(1, a, $urandom);
        for (int a = 0; a < 64; a++) wr_y(1, a, $urandom);
        model_run(1'b0);
        run(1, 1'b0, 1'b0, b, d, l);
        check("rnd_done_pulses", 32'(d), 32'd1);
        check("rnd_read_at_done", l, rz[63]);
        check_def_model("rnd_z");
        for (int a = 0; a < 64; a++) wr_x(1, a, $urandom);
        model_run(1'b1);
        run(1, 1'b1, 1'b0, b, d, l);
        check("rnd_acc_busy_cycles", 32'(b), 32'd640);
        check_def_model("rnd_acc_z");

        // 1x1x1 wrap
        wr_x(2, 0, 32'hFFFF_FFFF);
        wr_y(2, 0, 32'd2);
        run(2, 1'b0, 1'b0, b, d, l);
        check("wrap_busy_cycles", 32'(b), 32'd3);
        check("wrap_done_pulses", 32'(d), 32'd1);
        check("wrap_z", l, 32'hFFFF_FFFE);
        wr_x(2, 0, 32'd1);
        wr_y(2, 0, 32'd3);
        run(2, 1'b1, 1'b0, b, d, l);
        check("wrap_acc_z", l, 32'h0000_0001);
        rd_z(2, 0, v);
        check("wrap_acc_z_reread", v, 32'h0000_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
